// File: rtl/inst_rom_loader.sv
// Instruction memory with a combinational fetch port and a byte-stream
// program loader that holds the core in reset while loading.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  load_start_i,
    input  logic                  load_done_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    output logic                  load_ready_o,
    output logic                  cpu_rst_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o,
    output logic                  overflow_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] ptr_q, ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         word_q, word_d;
    logic                ovf_q, ovf_d;

    logic                wr_en;
    logic [31:0]         wr_word;
    logic [31:0]         word_acc;
    logic [2:0]          cnt_acc;
    logic                full;
    logic                addr_in_range;
    logic                unused_addr_bits;

    // Fetch: zero-latency read, NOP while loading or out of range
    assign addr_in_range    = (addr_i[31:ADDR_WIDTH+2] == '0);
    assign unused_addr_bits = &addr_i[1:0];

    always_comb begin
        inst_o = 32'h0;
        if (ce_i && (state_q == RUN) && addr_in_range) begin
            inst_o = mem[addr_i[ADDR_WIDTH+1:2]];
        end
    end

    // Core reset follows registered state only; no path from load inputs
    assign cpu_rst_o      = rst | (state_q != RUN);
    assign load_ready_o   = (state_q == LOAD);
    assign words_loaded_o = ptr_q;
    assign overflow_o     = ovf_q;
    assign full           = ptr_q[ADDR_WIDTH];

    // Next-state, byte assembly and memory write request
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_word  = 32'h0;
        word_acc = word_q;
        cnt_acc  = {1'b0, cnt_q};

        unique case (state_q)
            RUN: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    cnt_d   = 2'd0;
                    word_d  = 32'h0;
                    ovf_d   = 1'b0;
                end
            end

            LOAD: begin
                if (load_start_i) begin
                    // Restart wins over done; partial word discarded
                    ptr_d  = '0;
                    cnt_d  = 2'd0;
                    word_d = 32'h0;
                    ovf_d  = 1'b0;
                end else begin
                    if (load_valid_i) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            // Big-endian: first byte lands in the top lane
                            unique case (cnt_q)
                                2'd0: word_acc[31:24] = load_data_i;
                                2'd1: word_acc[23:16] = load_data_i;
                                2'd2: word_acc[15:8]  = load_data_i;
                                2'd3: word_acc[7:0]   = load_data_i;
                                default: word_acc = word_q;
                            endcase
                            cnt_acc = {1'b0, cnt_q} + 3'd1;
                        end
                    end

                    if (load_done_i) begin
                        // Flush any partial word, low bytes already zero
                        state_d = FLUSH;
                        if (cnt_acc != 3'd0) begin
                            wr_en   = 1'b1;
                            wr_word = word_acc;
                            ptr_d   = ptr_q + 1'b1;
                        end
                        cnt_d  = 2'd0;
                        word_d = 32'h0;
                    end else if (cnt_acc == 3'd4) begin
                        wr_en   = 1'b1;
                        wr_word = word_acc;
                        ptr_d   = ptr_q + 1'b1;
                        cnt_d   = 2'd0;
                        word_d  = 32'h0;
                    end else begin
                        cnt_d  = cnt_acc[1:0];
                        word_d = word_acc;
                    end
                end
            end

            FLUSH: begin
                state_d = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers; reset clears loader bookkeeping but not memory
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ptr_q   <= '0;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    // Memory write port; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

endmodule
